// File: rtl/sha256_block_feeder.sv
// rtl/sha256_block_feeder.sv - SHA-256 message padder and block sequencer for the compression core
//
// Reads NUM_OF_WORDS 32-bit words from word-addressed memory, applies SHA-256
// padding and hands one 16-word block at a time to the compression core. Each
// block's output hash is chained into the next block's input hash, starting
// from the SHA-256 IV. The final digest is presented on o_digest.
//
// Optional feature macro: SHA256_FEEDER_WRITEBACK_EN
//   defined   : after the last block the digest is written to memory at
//               output_addr..output_addr+7 (8 cycles, one word per cycle).
//   undefined : no writeback; o_mem_we and o_mem_write_data are tied to 0.
//
// Ports:
//   i_clk, i_reset_n      clock, asynchronous active-low reset
//   i_start               begin a hash (sampled only in IDLE)
//   i_message_addr        word address of message word 0 (latched on start)
//   i_output_addr         word address for digest writeback (latched on start)
//   o_done                high exactly when idle
//   o_digest[0:7]         final hash of the last completed run
//   o_mem_addr            memory word address (reads in FILL, writes in WR)
//   o_mem_we              memory write enable
//   o_mem_write_data      memory write data
//   i_mem_read_data       read data, valid one cycle after o_mem_addr
//   o_core_start          one-cycle start pulse to the core
//   i_core_done           core idle flag
//   o_core_hash[0:7]      chaining value presented to the core
//   o_core_message[0:15]  current padded block
//   i_core_digest[0:7]    core's output hash

module sha256_block_feeder #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic [15:0] i_message_addr,
    input  logic [15:0] i_output_addr,
    output logic        o_done,
    output logic [31:0] o_digest [0:7],
    output logic [15:0] o_mem_addr,
    output logic        o_mem_we,
    output logic [31:0] o_mem_write_data,
    input  logic [31:0] i_mem_read_data,
    output logic        o_core_start,
    input  logic        i_core_done,
    output logic [31:0] o_core_hash [0:7],
    output logic [31:0] o_core_message [0:15],
    input  logic [31:0] i_core_digest [0:7]
);

    // Room for the 0x80 marker word and the two length words decides whether
    // the padding fits in the final partial block or spills into an extra one.
    localparam int          LP_NB       = NUM_OF_WORDS / 16 + (((NUM_OF_WORDS % 16) < 14) ? 1 : 2);
    localparam logic [15:0] LP_N        = 16'(NUM_OF_WORDS);
    localparam logic [15:0] LP_LAST_BLK = 16'(LP_NB - 1);
    localparam logic [31:0] LP_LEN      = 32'(NUM_OF_WORDS * 32);

    localparam logic [31:0] LP_IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_KICK,
        S_WAITLO,
        S_WAITHI
`ifdef SHA256_FEEDER_WRITEBACK_EN
        , S_WR
`endif
    } state_t;

    state_t      r_state;
    logic [15:0] r_msg_addr;
    logic [15:0] r_blk;
    logic [4:0]  r_m;          // read-side word index; 16 is the drain cycle
    logic        r_pend;       // a memory word is in flight for r_pend_m
    logic [3:0]  r_pend_m;
    logic [15:0] r_mem_addr;
    logic        r_core_start;
    logic [31:0] r_digest       [0:7];
    logic [31:0] r_core_hash    [0:7];
    logic [31:0] r_core_message [0:15];

`ifdef SHA256_FEEDER_WRITEBACK_EN
    logic [15:0] r_out_addr;
    logic [2:0]  r_wr_k;
    logic        r_mem_we;
    logic [31:0] r_mem_wdata;
`else
    logic        w_unused_out_addr;
    assign w_unused_out_addr = ^i_output_addr;
`endif

    logic [15:0] w_blk_base;
    logic [15:0] w_g;
    logic [15:0] w_g_next;
    logic [15:0] w_next_blk_base;
    logic        w_blk_has_mem;
    logic        w_last_blk;
    logic [31:0] w_pad;

    function automatic logic [31:0] pad_word(input logic [15:0] g, input logic [3:0] m,
                                             input logic last);
        if (g == LP_N) begin
            return 32'h80000000;
        end else if (last && (m == 4'd15)) begin
            return LP_LEN;
        end else begin
            return 32'h0;
        end
    endfunction

    assign w_blk_base      = {r_blk[11:0], 4'b0000};
    assign w_g             = w_blk_base + {11'd0, r_m};
    assign w_g_next        = w_g + 16'd1;
    assign w_next_blk_base = {r_blk[11:0] + 12'd1, 4'b0000};
    assign w_blk_has_mem   = (w_blk_base < LP_N);
    assign w_last_blk      = (r_blk == LP_LAST_BLK);
    assign w_pad           = pad_word(w_g, r_m[3:0], w_last_blk);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_msg_addr   <= '0;
            r_blk        <= '0;
            r_m          <= '0;
            r_pend       <= 1'b0;
            r_pend_m     <= '0;
            r_mem_addr   <= '0;
            r_core_start <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_digest[i]    <= '0;
                r_core_hash[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                r_core_message[i] <= '0;
            end
`ifdef SHA256_FEEDER_WRITEBACK_EN
            r_out_addr  <= '0;
            r_wr_k      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_msg_addr <= i_message_addr;
                        // Word 0 is always a memory word, so its read goes out in the first FILL cycle.
                        r_mem_addr <= i_message_addr;
                        r_blk      <= '0;
                        r_m        <= '0;
                        r_pend     <= 1'b0;
                        for (int i = 0; i < 8; i++) begin
                            r_core_hash[i] <= LP_IV[i];
                        end
`ifdef SHA256_FEEDER_WRITEBACK_EN
                        r_out_addr <= i_output_addr;
`endif
                        r_state    <= S_FILL;
                    end
                end

                S_FILL: begin
                    if (r_pend) begin
                        r_core_message[r_pend_m] <= i_mem_read_data;
                    end
                    if (r_m == 5'd16) begin
                        r_pend       <= 1'b0;
                        r_m          <= '0;
                        r_core_start <= 1'b1;
                        r_state      <= S_KICK;
                    end else begin
                        if (w_g < LP_N) begin
                            r_pend   <= 1'b1;
                            r_pend_m <= r_m[3:0];
                        end else begin
                            r_pend                   <= 1'b0;
                            r_core_message[r_m[3:0]] <= w_pad;
                        end
                        // Address is held once the message runs out, so padding causes no bus activity.
                        if ((r_m != 5'd15) && (w_g_next < LP_N)) begin
                            r_mem_addr <= r_msg_addr + w_g_next;
                        end
                        // An all-padding block has nothing in flight, so it skips the drain cycle.
                        if ((r_m == 5'd15) && !w_blk_has_mem) begin
                            r_m          <= '0;
                            r_core_start <= 1'b1;
                            r_state      <= S_KICK;
                        end else begin
                            r_m <= r_m + 5'd1;
                        end
                    end
                end

                S_KICK: begin
                    r_core_start <= 1'b0;
                    r_state      <= S_WAITLO;
                end

                S_WAITLO: begin
                    if (!i_core_done) begin
                        r_state <= S_WAITHI;
                    end
                end

                S_WAITHI: begin
                    if (i_core_done) begin
                        for (int i = 0; i < 8; i++) begin
                            r_core_hash[i] <= i_core_digest[i];
                        end
                        if (!w_last_blk) begin
                            r_blk <= r_blk + 16'd1;
                            if (w_next_blk_base < LP_N) begin
                                r_mem_addr <= r_msg_addr + w_next_blk_base;
                            end
                            r_state <= S_FILL;
                        end else begin
                            for (int i = 0; i < 8; i++) begin
                                r_digest[i] <= i_core_digest[i];
                            end
`ifdef SHA256_FEEDER_WRITEBACK_EN
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_out_addr;
                            r_mem_wdata <= i_core_digest[0];
                            r_wr_k      <= '0;
                            r_state     <= S_WR;
`else
                            r_state     <= S_IDLE;
`endif
                        end
                    end
                end

`ifdef SHA256_FEEDER_WRITEBACK_EN
                S_WR: begin
                    if (r_wr_k == 3'd7) begin
                        r_mem_we <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_wr_k      <= r_wr_k + 3'd1;
                        r_mem_addr  <= r_out_addr + {13'd0, r_wr_k + 3'd1};
                        r_mem_wdata <= r_digest[r_wr_k + 3'd1];
                    end
                end
`endif

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_done         = (r_state == S_IDLE);
    assign o_mem_addr     = r_mem_addr;
    assign o_core_start   = r_core_start;
    assign o_digest       = r_digest;
    assign o_core_hash    = r_core_hash;
    assign o_core_message = r_core_message;

`ifdef SHA256_FEEDER_WRITEBACK_EN
    assign o_mem_we         = r_mem_we;
    assign o_mem_write_data = r_mem_wdata;
`else
    assign o_mem_we         = 1'b0;
    assign o_mem_write_data = 32'h0;
`endif

endmodule

// File: tb/tb_sha256_block_feeder.sv
// tb/tb_sha256_block_feeder.sv - directed bench for sha256_block_feeder at N=20, 14 and 13
module tb_sha256_block_feeder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        clr;
    logic [15:0] message_addr;
    logic [15:0] output_addr;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SHA256_FEEDER_WRITEBACK_EN
    localparam int WB = 8;
`else
    localparam int WB = 0;
`endif

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Three feeders share stimulus; each has its own memory model and stub core.
    // Memory word at address a reads back as a. Stub core returns core_hash[k]+k+1
    // after holding done low for 5 cycles; it ignores reset so an in-flight result
    // still arrives after a mid-run reset.
    for (genvar k = 0; k < 3; k++) begin : g_u
        localparam int NWK = (k == 0) ? 20 : ((k == 1) ? 14 : 13);

        logic        done;
        logic        mem_we;
        logic        core_start;
        logic        core_done = 1'b1;
        logic [15:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] rd = 32'h0;
        logic [31:0] digest       [0:7];
        logic [31:0] core_hash    [0:7];
        logic [31:0] core_message [0:15];
        logic [31:0] core_dig     [0:7] = '{default: 32'h0};

        int          cnt = 0;
        int          nblk = 0;
        int          cyc = 0;
        int          busy = 0;
        int          chg = 0;
        int          we_cnt = 0;
        logic [31:0] we_data0 = 32'h0;
        logic [15:0] we_addr0 = 16'h0;
        logic [15:0] prev_addr = 16'h0;
        logic        prev_busy = 1'b0;
        logic [31:0] cap_msg  [0:3][0:15];
        logic [31:0] cap_hash [0:3][0:7];
        int          cap_t    [0:3];

        sha256_block_feeder #(.NUM_OF_WORDS(NWK)) u_dut (
            .i_clk            (clk),
            .i_reset_n        (reset_n),
            .i_start          (start),
            .i_message_addr   (message_addr),
            .i_output_addr    (output_addr),
            .o_done           (done),
            .o_digest         (digest),
            .o_mem_addr       (mem_addr),
            .o_mem_we         (mem_we),
            .o_mem_write_data (mem_wdata),
            .i_mem_read_data  (rd),
            .o_core_start     (core_start),
            .i_core_done      (core_done),
            .o_core_hash      (core_hash),
            .o_core_message   (core_message),
            .i_core_digest    (core_dig)
        );

        always @(posedge clk) begin
            rd  <= {16'h0, mem_addr};
            cyc <= cyc + 1;
            if (core_start) begin
                core_done <= 1'b0;
                cnt       <= 5;
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    core_done <= 1'b1;
                    for (int j = 0; j < 8; j++) core_dig[j] <= core_hash[j] + 32'(j + 1);
                end
            end
            if (clr) begin
                nblk   <= 0;
                we_cnt <= 0;
            end else begin
                if (core_start && nblk < 4) begin
                    for (int j = 0; j < 16; j++) cap_msg[nblk][j] <= core_message[j];
                    for (int j = 0; j < 8; j++) cap_hash[nblk][j] <= core_hash[j];
                    cap_t[nblk] <= cyc;
                    nblk        <= nblk + 1;
                end
                if (mem_we) begin
                    if (we_cnt == 0) begin
                        we_data0 <= mem_wdata;
                        we_addr0 <= mem_addr;
                    end
                    we_cnt <= we_cnt + 1;
                end
            end
        end

        always @(negedge clk) begin
            if (clr) begin
                busy <= 0;
                chg  <= 0;
            end else begin
                if (!done) busy <= busy + 1;
                if (!done && prev_busy && mem_addr != prev_addr) chg <= chg + 1;
            end
            prev_addr <= mem_addr;
            prev_busy <= !done;
        end
    end

    task automatic start_run(input logic [15:0] base, input logic hold);
        @(negedge clk);
        clr = 1'b1;
        message_addr = base;
        output_addr  = 16'h0200;
        @(negedge clk);
        @(negedge clk);
        clr   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic only0, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (g_u[0].done && (only0 || (g_u[1].done && g_u[2].done))) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_eq(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        logic ok;
        reset_n      = 1'b0;
        start        = 1'b0;
        clr          = 1'b0;
        message_addr = 16'h0;
        output_addr  = 16'h0;
        repeat (3) @(negedge clk);

        check_eq("rst_done",       32'(g_u[0].done), 32'd1);
        check_eq("rst_core_start", 32'(g_u[0].core_start), 32'd0);
        check_eq("rst_mem_we",     32'(g_u[0].mem_we), 32'd0);
        check_eq("rst_mem_addr",   {16'h0, g_u[0].mem_addr}, 32'd0);
        check_eq("rst_mem_wdata",  g_u[0].mem_wdata, 32'd0);
        check_eq("rst_digest0",    g_u[0].digest[0], 32'd0);
        check_eq("rst_hash0",      g_u[0].core_hash[0], 32'd0);
        check_eq("rst_msg0",       g_u[0].core_message[0], 32'd0);
        reset_n = 1'b1;

        // Run 1: message at address 0, so word i reads back as i.
        start_run(16'h0000, 1'b0);
        wait_done("run1_timeout", 1'b0, 400);
        check_eq("n20_blocks",   g_u[0].nblk, 32'd2);
        check_eq("n20_cycles",   g_u[0].busy, 32'(48 + WB));
        check_eq("n20_b0_hash0", g_u[0].cap_hash[0][0], 32'h6a09e667);
        check_eq("n20_b1_hash0", g_u[0].cap_hash[1][0], 32'h6a09e668);
        check_eq("n20_b1_hash7", g_u[0].cap_hash[1][7], 32'h5be0cd21);
        check_eq("n20_b0_w0",    g_u[0].cap_msg[0][0], 32'd0);
        check_eq("n20_b0_w15",   g_u[0].cap_msg[0][15], 32'd15);
        check_eq("n20_b1_w3",    g_u[0].cap_msg[1][3], 32'd19);
        check_eq("n20_b1_w4",    g_u[0].cap_msg[1][4], 32'h80000000);
        check_eq("n20_b1_w14",   g_u[0].cap_msg[1][14], 32'h0);
        check_eq("n20_b1_w15",   g_u[0].cap_msg[1][15], 32'h00000280);
        check_eq("n20_gap",      g_u[0].cap_t[1] - g_u[0].cap_t[0], 32'd24);
        check_eq("n20_digest0",  g_u[0].digest[0], 32'h6a09e669);
        check_eq("n20_digest7",  g_u[0].digest[7], 32'h5be0cd29);
        check_eq("n20_addr_chg", g_u[0].chg, 32'(19 + WB));
        check_eq("n20_we_cnt",   g_u[0].we_cnt, 32'(WB));
`ifdef SHA256_FEEDER_WRITEBACK_EN
        check_eq("n20_wb_data0", g_u[0].we_data0, 32'h6a09e669);
        check_eq("n20_wb_addr0", {16'h0, g_u[0].we_addr0}, 32'h00000200);
`endif

        check_eq("n14_blocks",   g_u[1].nblk, 32'd2);
        check_eq("n14_cycles",   g_u[1].busy, 32'(47 + WB));
        check_eq("n14_b0_w13",   g_u[1].cap_msg[0][13], 32'd13);
        check_eq("n14_b0_w14",   g_u[1].cap_msg[0][14], 32'h80000000);
        check_eq("n14_b0_w15",   g_u[1].cap_msg[0][15], 32'h0);
        check_eq("n14_b1_w0",    g_u[1].cap_msg[1][0], 32'h0);
        check_eq("n14_b1_w14",   g_u[1].cap_msg[1][14], 32'h0);
        check_eq("n14_b1_w15",   g_u[1].cap_msg[1][15], 32'h000001c0);
        check_eq("n14_gap",      g_u[1].cap_t[1] - g_u[1].cap_t[0], 32'd23);
        check_eq("n14_addr_chg", g_u[1].chg, 32'(13 + WB));

        check_eq("n13_blocks",   g_u[2].nblk, 32'd1);
        check_eq("n13_cycles",   g_u[2].busy, 32'(24 + WB));
        check_eq("n13_b0_w12",   g_u[2].cap_msg[0][12], 32'd12);
        check_eq("n13_b0_w13",   g_u[2].cap_msg[0][13], 32'h80000000);
        check_eq("n13_b0_w14",   g_u[2].cap_msg[0][14], 32'h0);
        check_eq("n13_b0_w15",   g_u[2].cap_msg[0][15], 32'h000001a0);
        check_eq("n13_digest0",  g_u[2].digest[0], 32'h6a09e668);
        check_eq("n13_digest7",  g_u[2].digest[7], 32'h5be0cd21);

        // Reset asserted between clock edges while block 0 waits in WAITHI.
        start_run(16'h0000, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (g_u[0].nblk >= 1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("rst_wait_kick", {31'd0, ok}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_done",       32'(g_u[0].done), 32'd1);
        check_eq("mid_rst_core_start", 32'(g_u[0].core_start), 32'd0);
        check_eq("mid_rst_hash0",      g_u[0].core_hash[0], 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("post_rst_done",    32'(g_u[0].done), 32'd1);
        check_eq("post_rst_digest0", g_u[0].digest[0], 32'd0);
        check_eq("post_rst_we_cnt",  g_u[0].we_cnt, 32'd0);

        start_run(16'h0000, 1'b0);
        wait_done("rerun_timeout", 1'b0, 400);
        check_eq("rerun_blocks",  g_u[0].nblk, 32'd2);
        check_eq("rerun_cycles",  g_u[0].busy, 32'(48 + WB));
        check_eq("rerun_digest0", g_u[0].digest[0], 32'h6a09e669);
        check_eq("rerun_n13_dig", g_u[2].digest[0], 32'h6a09e668);

        // Start held high through the run; addresses wrap past ffff.
        start_run(16'hfff8, 1'b1);
        wait_done("held_timeout", 1'b1, 400);
        check_eq("held_blocks",   g_u[0].nblk, 32'd2);
        check_eq("held_cycles",   g_u[0].busy, 32'(48 + WB));
        check_eq("wrap_b0_w0",    g_u[0].cap_msg[0][0], 32'h0000fff8);
        check_eq("wrap_b0_w7",    g_u[0].cap_msg[0][7], 32'h0000ffff);
        check_eq("wrap_b0_w8",    g_u[0].cap_msg[0][8], 32'h00000000);
        check_eq("wrap_b1_w3",    g_u[0].cap_msg[1][3], 32'h0000000b);
        check_eq("wrap_b1_w4",    g_u[0].cap_msg[1][4], 32'h80000000);
        check_eq("wrap_addr_chg", g_u[0].chg, 32'(19 + WB));
        check_eq("wrap_digest0",  g_u[0].digest[0], 32'h6a09e669);
        repeat (2) @(negedge clk);
        check_eq("held_no_restart", 32'(g_u[0].done), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
